uart_pixel_framer: RTL and testbench

Framing and width-conversion stage between the UART byte streams and the pixel-processing pipeline. Assembles received bytes into multi-byte pixels, tags each pixel with start-of-frame, end-of-line and end-of-frame from internal column/row counters, and serialises processed results back into scaled, saturated, replicated bytes for transmission. It generalises the fixed widen/narrow path: configurable bytes per pixel, output precision, output byte count and frame geometry.

---
 rtl/uart_pixel_framer.sv | 178 +++++++++++++++++
 tb/tb_uart_pixel_framer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pixel_framer.sv
// UART byte <-> pixel framing stage.
// Packs bytes into tagged pixels and serialises scaled results.
module uart_pixel_framer #(
  parameter int in_bytes_p     = 3,
  parameter int linewidth_px_p = 480,
  parameter int frame_lines_p  = 272,
  parameter int width_out_p    = 16,
  parameter int out_shift_p    = 8,
  parameter int out_bytes_p    = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     byte_valid_i,
  output logic                     byte_ready_o,
  input  logic [7:0]               byte_i,
  output logic                     px_valid_o,
  input  logic                     px_ready_i,
  output logic [8*in_bytes_p-1:0]  px_data_o,
  output logic                     px_sof_o,
  output logic                     px_eol_o,
  output logic                     px_eof_o,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [width_out_p-1:0]   res_data_i,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [7:0]               tx_byte_o,
  output logic                     frame_done_o
);

  localparam int PW = 8 * in_bytes_p;
  localparam int IW = (in_bytes_p > 1) ? $clog2(in_bytes_p) : 1;
  localparam int CW = $clog2(linewidth_px_p);
  localparam int RW = (frame_lines_p > 1) ? $clog2(frame_lines_p) : 1;
  localparam int KW = (out_bytes_p > 1) ? $clog2(out_bytes_p) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(in_bytes_p - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(linewidth_px_p - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(frame_lines_p - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(out_bytes_p - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] asm_q, asm_d;
  logic [PW-1:0] px_q, px_d;
  logic          pv_q, pv_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;

  logic          busy_q, busy_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    sc_q, sc_d;

  logic last_byte, byte_hs, px_hs, eol_w, eof_w;
  logic tx_hs, tx_last, res_hs;
  logic [width_out_p-1:0] shifted;
  logic [7:0] scaled_w;

  assign last_byte    = (idx_q == IDX_LAST);
  assign byte_ready_o = !last_byte || !pv_q || px_ready_i;
  assign byte_hs      = byte_valid_i && byte_ready_o;
  assign px_hs        = pv_q && px_ready_i;
  assign eol_w        = (col_q == COL_LAST);
  assign eof_w        = eol_w && (row_q == ROW_LAST);

  assign px_valid_o   = pv_q;
  assign px_data_o    = px_q;
  assign px_sof_o     = sof_q;
  assign px_eol_o     = eol_q;
  assign px_eof_o     = eof_q;
  assign frame_done_o = done_q;

  // Byte assembly, pixel hand-off and frame position tracking.
  always_comb begin
    idx_d  = idx_q;
    asm_d  = asm_q;
    px_d   = px_q;
    pv_d   = pv_q;
    sof_d  = sof_q;
    eol_d  = eol_q;
    eof_d  = eof_q;
    col_d  = col_q;
    row_d  = row_q;
    done_d = px_hs && eof_q;
    if (px_hs) pv_d = 1'b0;
    if (byte_hs) begin
      asm_d[{idx_q, 3'b000} +: 8] = byte_i;
      if (last_byte) begin
        idx_d = '0;
        px_d  = asm_d;
        pv_d  = 1'b1;
        sof_d = (col_q == '0) && (row_q == '0);
        eol_d = eol_w;
        eof_d = eof_w;
        if (eol_w) begin
          col_d = '0;
          row_d = eof_w ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Input half state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      asm_q  <= '0;
      px_q   <= '0;
      pv_q   <= 1'b0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      eof_q  <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      px_q   <= px_d;
      pv_q   <= pv_d;
      sof_q  <= sof_d;
      eol_q  <= eol_d;
      eof_q  <= eof_d;
      col_q  <= col_d;
      row_q  <= row_d;
      done_q <= done_d;
    end
  end

  assign shifted     = res_data_i >> out_shift_p;
  assign scaled_w    = (shifted > width_out_p'(255)) ? 8'hFF : shifted[7:0];
  assign tx_valid_o  = busy_q;
  assign tx_byte_o   = sc_q;
  assign tx_hs       = busy_q && tx_ready_i;
  assign tx_last     = (k_q == K_LAST);
  assign res_ready_o = !busy_q || (tx_hs && tx_last);
  assign res_hs      = res_valid_i && res_ready_o;

  // Result capture and replicated byte serialisation.
  always_comb begin
    busy_d = busy_q;
    k_d    = k_q;
    sc_d   = sc_q;
    if (tx_hs) begin
      if (tx_last) begin
        busy_d = 1'b0;
        k_d    = '0;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
    if (res_hs) begin
      busy_d = 1'b1;
      sc_d   = scaled_w;
    end
  end

  // Output half state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      k_q    <= '0;
      sc_q   <= '0;
    end else begin
      busy_q <= busy_d;
      k_q    <= k_d;
      sc_q   <= sc_d;
    end
  end

endmodule

// File: tb/tb_uart_pixel_framer.sv
// Bench for uart_pixel_framer: two configurations,
// queue-level reference model plus directed literal checks.
module tb_uart_pixel_framer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       bv  [2];
  logic [7:0] bd  [2];
  logic       pxr [2];
  logic       rv  [2];
  logic [15:0] rd [2];
  logic       tr  [2];
  logic       br  [2];
  logic       pv  [2];
  logic       sof [2];
  logic       eol [2];
  logic       eof [2];
  logic       rr  [2];
  logic       tv  [2];
  logic [7:0] txb [2];
  logic       fd  [2];
  logic [23:0] pxd0;
  logic [7:0]  pxd1;

  uart_pixel_framer #(
    .in_bytes_p(3), .linewidth_px_p(4), .frame_lines_p(2),
    .width_out_p(16), .out_shift_p(8), .out_bytes_p(3)
  ) u0 (
    .clk_i(clk), .reset_i(rst),
    .byte_valid_i(bv[0]), .byte_ready_o(br[0]), .byte_i(bd[0]),
    .px_valid_o(pv[0]), .px_ready_i(pxr[0]), .px_data_o(pxd0),
    .px_sof_o(sof[0]), .px_eol_o(eol[0]), .px_eof_o(eof[0]),
    .res_valid_i(rv[0]), .res_ready_o(rr[0]), .res_data_i(rd[0]),
    .tx_valid_o(tv[0]), .tx_ready_i(tr[0]), .tx_byte_o(txb[0]),
    .frame_done_o(fd[0])
  );

  uart_pixel_framer #(
    .in_bytes_p(1), .linewidth_px_p(2), .frame_lines_p(1),
    .width_out_p(16), .out_shift_p(4), .out_bytes_p(1)
  ) u1 (
    .clk_i(clk), .reset_i(rst),
    .byte_valid_i(bv[1]), .byte_ready_o(br[1]), .byte_i(bd[1]),
    .px_valid_o(pv[1]), .px_ready_i(pxr[1]), .px_data_o(pxd1),
    .px_sof_o(sof[1]), .px_eol_o(eol[1]), .px_eof_o(eof[1]),
    .res_valid_i(rv[1]), .res_ready_o(rr[1]), .res_data_i(rd[1]),
    .tx_valid_o(tv[1]), .tx_ready_i(tr[1]), .tx_byte_o(txb[1]),
    .frame_done_o(fd[1])
  );

  function automatic int ib(int i); return (i == 0) ? 3 : 1; endfunction
  function automatic int lw(int i); return (i == 0) ? 4 : 2; endfunction
  function automatic int fl(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int sh(int i); return (i == 0) ? 8 : 4; endfunction
  function automatic int ob(int i); return (i == 0) ? 3 : 1; endfunction

  function automatic logic [31:0] pxdat(int i);
    return (i == 0) ? 32'(pxd0) : 32'(pxd1);
  endfunction

  function automatic logic [7:0] sat(logic [15:0] v, int s);
    logic [15:0] t;
    t = v >> s;
    return (t > 16'd255) ? 8'hFF : t[7:0];
  endfunction

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(string nm, int i, logic [31:0] a, logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      if (nerr < 40)
        $display("FAIL %s[%0d] @%0t: got %h want %h", nm, i, $time, a, e);
    end
  endtask

  // reference model state
  int          m_nb  [2];
  logic [31:0] m_acc [2];
  logic [31:0] m_px  [2];
  bit          m_pv  [2];
  bit          m_sof [2];
  bit          m_eol [2];
  bit          m_eof [2];
  int          m_n   [2];
  bit          m_done[2];
  bit          m_busy[2];
  int          m_k   [2];
  logic [7:0]  m_sc  [2];

  function automatic bit e_br(int i);
    return (m_nb[i] != ib(i) - 1) || !m_pv[i] || pxr[i];
  endfunction

  function automatic bit e_rr(int i);
    return !m_busy[i] || (tr[i] && m_k[i] == ob(i) - 1);
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      bv[i] = 0; bd[i] = 0; pxr[i] = 0;
      rv[i] = 0; rd[i] = 0; tr[i] = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_nb[i] = 0; m_acc[i] = 0; m_px[i] = 0; m_pv[i] = 0;
        m_sof[i] = 0; m_eol[i] = 0; m_eof[i] = 0; m_n[i] = 0;
        m_done[i] = 0; m_busy[i] = 0; m_k[i] = 0; m_sc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit bhs, phs, rhs, ths;
        int fr;
        bhs = bv[i] && e_br(i);
        phs = m_pv[i] && pxr[i];
        ths = m_busy[i] && tr[i];
        rhs = rv[i] && e_rr(i);
        fr  = lw(i) * fl(i);
        m_done[i] = phs && m_eof[i];
        if (phs) m_pv[i] = 0;
        if (bhs) begin
          m_acc[i] = m_acc[i] | (32'(bd[i]) << (8 * m_nb[i]));
          m_nb[i]++;
          if (m_nb[i] == ib(i)) begin
            m_px[i]  = m_acc[i];
            m_sof[i] = (m_n[i] == 0);
            m_eol[i] = (m_n[i] % lw(i)) == lw(i) - 1;
            m_eof[i] = (m_n[i] == fr - 1);
            m_n[i]   = (m_n[i] + 1) % fr;
            m_pv[i]  = 1;
            m_acc[i] = 0;
            m_nb[i]  = 0;
          end
        end
        if (ths) begin
          if (m_k[i] == ob(i) - 1) begin
            m_busy[i] = 0;
            m_k[i] = 0;
          end else begin
            m_k[i]++;
          end
        end
        if (rhs) begin
          m_busy[i] = 1;
          m_sc[i] = sat(rd[i], sh(i));
        end
      end
    end
  end

  // observed handshake logs: {eof,eol,sof} in [26:24]
  logic [31:0] pl0[$];
  logic [31:0] pl1[$];
  logic [7:0]  tl0[$];
  logic [7:0]  tl1[$];
  int fdc[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("byte_ready", i, 32'(br[i]), 32'(e_br(i)));
      chk("px_valid", i, 32'(pv[i]), 32'(m_pv[i]));
      if (m_pv[i]) begin
        chk("px_data", i, pxdat(i), m_px[i]);
        chk("px_sof", i, 32'(sof[i]), 32'(m_sof[i]));
        chk("px_eol", i, 32'(eol[i]), 32'(m_eol[i]));
        chk("px_eof", i, 32'(eof[i]), 32'(m_eof[i]));
      end
      chk("frame_done", i, 32'(fd[i]), 32'(m_done[i]));
      chk("res_ready", i, 32'(rr[i]), 32'(e_rr(i)));
      chk("tx_valid", i, 32'(tv[i]), 32'(m_busy[i]));
      if (m_busy[i]) chk("tx_byte", i, 32'(txb[i]), 32'(m_sc[i]));
      if (pv[i] && pxr[i]) begin
        logic [31:0] ent;
        ent = (32'(eof[i]) << 26) | (32'(eol[i]) << 25) |
              (32'(sof[i]) << 24) | pxdat(i);
        if (i == 0) pl0.push_back(ent);
        else pl1.push_back(ent);
      end
      if (tv[i] && tr[i]) begin
        if (i == 0) tl0.push_back(txb[i]);
        else tl1.push_back(txb[i]);
      end
      if (fd[i]) fdc[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, output int t);
    bit acc;
    bv[i] = 1; bd[i] = b; t = 0; acc = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = br[i];
      tick();
      t++;
    end
    if (!acc) chk("byte_timeout", i, 0, 1);
  endtask

  task automatic send_res(input int i, input logic [15:0] v);
    bit acc;
    int t;
    rv[i] = 1; rd[i] = v; t = 0; acc = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = rr[i];
      tick();
      t++;
    end
    if (!acc) chk("res_timeout", i, 0, 1);
  endtask

  bit tog_done;

  initial begin
    int t, tsum;
    #2 rst = 1;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_byte_ready", i, 32'(br[i]), 1);
      chk("rst_res_ready", i, 32'(rr[i]), 1);
      chk("rst_px_valid", i, 32'(pv[i]), 0);
      chk("rst_tx_valid", i, 32'(tv[i]), 0);
    end
    rst = 0;
    tick();

    // frame tagging, 3-byte pixels, 4x2 frame
    pxr[0] = 1;
    pl0.delete(); fdc[0] = 0;
    for (int b = 1; b <= 27; b++) send_byte(0, 8'(b), t);
    bv[0] = 0;
    repeat (3) tick();
    chk("n_pixels", 0, 32'(pl0.size()), 9);
    if (pl0.size() == 9) begin
      chk("pix0", 0, pl0[0], 32'h01030201);
      chk("pix1", 0, pl0[1], 32'h00060504);
      chk("pix3", 0, pl0[3], 32'h020C0B0A);
      chk("pix4", 0, pl0[4], 32'h000F0E0D);
      chk("pix7", 0, pl0[7], 32'h06181716);
      chk("pix8", 0, pl0[8], 32'h011B1A19);
    end
    chk("frame_done_cnt", 0, 32'(fdc[0]), 1);

    // backpressure with held pixel
    pl0.delete();
    pxr[0] = 0;
    for (int b = 8'h21; b <= 8'h25; b++) send_byte(0, 8'(b), t);
    bd[0] = 8'h26;
    repeat (3) tick();
    @(negedge clk);
    chk("stall_ready", 0, 32'(br[0]), 0);
    chk("stall_data", 0, pxdat(0), 32'h00232221);
    tick();
    pxr[0] = 1;
    tick();
    tsum = 0;
    for (int b = 8'h27; b <= 8'h2C; b++) begin
      send_byte(0, 8'(b), t);
      tsum += t;
    end
    bv[0] = 0;
    repeat (3) tick();
    chk("stream_cycles", 0, 32'(tsum), 6);
    chk("n_pixels2", 0, 32'(pl0.size()), 4);
    if (pl0.size() == 4) begin
      chk("bp_pix0", 0, pl0[0], 32'h00232221);
      chk("bp_pix1", 0, pl0[1], 32'h00262524);
      chk("bp_pix2", 0, pl0[2], 32'h02292827);
      chk("bp_pix3", 0, pl0[3], 32'h002C2B2A);
    end

    // scaling, saturation and replication
    tl0.delete(); tl1.delete();
    tr[0] = 1; tr[1] = 1;
    send_res(0, 16'h1234);
    send_res(0, 16'h00FF);
    send_res(0, 16'hFFFF);
    rv[0] = 0;
    send_res(1, 16'h1234);
    send_res(1, 16'h00FF);
    send_res(1, 16'h0100);
    rv[1] = 0;
    repeat (12) tick();
    chk("n_tx0", 0, 32'(tl0.size()), 9);
    if (tl0.size() == 9) begin
      chk("tx0_0", 0, 32'(tl0[0]), 32'h12);
      chk("tx0_2", 0, 32'(tl0[2]), 32'h12);
      chk("tx0_3", 0, 32'(tl0[3]), 32'h00);
      chk("tx0_5", 0, 32'(tl0[5]), 32'h00);
      chk("tx0_6", 0, 32'(tl0[6]), 32'hFF);
      chk("tx0_8", 0, 32'(tl0[8]), 32'hFF);
    end
    chk("n_tx1", 1, 32'(tl1.size()), 3);
    if (tl1.size() == 3) begin
      chk("tx1_0", 1, 32'(tl1[0]), 32'hFF);
      chk("tx1_1", 1, 32'(tl1[1]), 32'h0F);
      chk("tx1_2", 1, 32'(tl1[2]), 32'h10);
    end

    // random tx backpressure, res_valid held high
    tl0.delete();
    tog_done = 0;
    fork
      begin
        for (int r = 0; r < 6; r++) send_res(0, 16'($urandom));
        rv[0] = 0;
        tog_done = 1;
      end
      begin
        while (!tog_done) begin
          tr[0] = 1'($urandom_range(1, 0));
          tick();
        end
        tr[0] = 1;
      end
    join
    repeat (12) tick();
    chk("n_tx_rand", 0, 32'(tl0.size()), 18);

    // reset mid-pixel and mid-transmit
    send_byte(0, 8'h31, t);
    send_byte(0, 8'h32, t);
    bv[0] = 0;
    tr[0] = 0;
    send_res(0, 16'h5600);
    rv[0] = 0;
    tick();
    rst = 1;
    #1;
    chk("mid_rst_byte_ready", 0, 32'(br[0]), 1);
    chk("mid_rst_res_ready", 0, 32'(rr[0]), 1);
    chk("mid_rst_tx_valid", 0, 32'(tv[0]), 0);
    chk("mid_rst_tx_byte", 0, 32'(txb[0]), 0);
    chk("mid_rst_px_valid", 0, 32'(pv[0]), 0);
    chk("mid_rst_px_data", 0, pxdat(0), 0);
    chk("mid_rst_frame_done", 0, 32'(fd[0]), 0);
    tick();
    rst = 0;
    tr[0] = 1;
    tick();
    pl0.delete();
    send_byte(0, 8'hA1, t);
    send_byte(0, 8'hA2, t);
    send_byte(0, 8'hA3, t);
    bv[0] = 0;
    repeat (3) tick();
    chk("post_rst_n", 0, 32'(pl0.size()), 1);
    if (pl0.size() == 1) chk("post_rst_pix", 0, pl0[0], 32'h01A3A2A1);

    // single-byte pixels, 2x1 frame
    pl1.delete(); fdc[1] = 0;
    pxr[1] = 1;
    for (int b = 8'h51; b <= 8'h54; b++) send_byte(1, 8'(b), t);
    bv[1] = 0;
    repeat (3) tick();
    chk("n_pix1", 1, 32'(pl1.size()), 4);
    if (pl1.size() == 4) begin
      chk("p1_0", 1, pl1[0], 32'h01000051);
      chk("p1_1", 1, pl1[1], 32'h06000052);
      chk("p1_2", 1, pl1[2], 32'h01000053);
      chk("p1_3", 1, pl1[3], 32'h06000054);
    end
    chk("frame_done_cnt1", 1, 32'(fdc[1]), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
